// File: rtl/lspc_pkg.sv
// Shared types and constants for the LSPC VRAM CPU port.
// Bit 15 of a VRAM address selects the fast (high) VRAM; the lower 15 bits are the word offset.
package lspc_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_WAIT = 3'd1,
        ST_WR_DO   = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DO   = 3'd4,
        ST_RD_CAP  = 3'd5
    } port_state_e;

    localparam word_t VRAM_LOW_FIRST  = 16'h0000;
    localparam word_t VRAM_LOW_LAST   = 16'h7FFF;
    localparam word_t VRAM_HIGH_FIRST = 16'h8000;
    localparam word_t VRAM_HIGH_LAST  = 16'hFFFF;

    function automatic logic isHighRegion(input word_t addr);
        return addr >= VRAM_HIGH_FIRST;
    endfunction

endpackage

// File: rtl/lspc_vram_addr_step.sv
// Combinational VRAM address auto-increment for the LSPC CPU port.
// The 15-bit offset wraps on its own; the region bit never changes.
module lspc_vram_addr_step
    import lspc_pkg::*;
(
    input  logic [15:0] addr_i,
    input  logic [15:0] mod_i,
    output logic [15:0] addrNext_o
);

    logic [14:0] offsetSum;
    logic        unusedModSign;

    // The step's top bit is discarded, so 0xFFFF behaves as -1 within the region.
    assign offsetSum     = addr_i[14:0] + mod_i[14:0];
    assign addrNext_o    = {addr_i[15], offsetSum};
    assign unusedModSign = mod_i[15];

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// LSPC VRAM CPU port: moves CPU writes and prefetch reads into the VRAM access slots.
// Optional macro LSPC_CPU_PORT_OVERCLOCK_EN adds overclock_i, letting waits proceed without a slot.
module lspc_vram_cpu_port
    import lspc_pkg::*;
(
`ifdef LSPC_CPU_PORT_OVERCLOCK_EN
    input  logic        overclock_i,
`endif
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        addrLoad_i,
    input  logic [15:0] regVramAddr_i,
    input  logic [15:0] regVramMod_i,
    input  logic [15:0] regVramRw_i,
    input  logic        vramWriteReq_i,
    input  logic        cpuSlot_i,
    output logic [15:0] vramAddr_o,
    output logic [15:0] vramWdata_o,
    output logic        vramLowWe_o,
    output logic        vramHighWe_o,
    output logic        vramRd_o,
    input  logic [15:0] vramRdata_i,
    output logic [15:0] vramLowRead_o,
    output logic [15:0] vramHighRead_o,
    output logic        writeDone_o,
    output logic        busy_o
);

    port_state_e state_q;
    logic [15:0] addr_q;
    logic [15:0] addrStep_d;
    logic [15:0] writeData_q;
    logic [15:0] lowRead_q;
    logic [15:0] highRead_q;
    logic        lowWe_q;
    logic        highWe_q;
    logic        rd_q;
    logic        writeDone_q;
    logic        slotGo;

`ifdef LSPC_CPU_PORT_OVERCLOCK_EN
    assign slotGo = cpuSlot_i | overclock_i;
`else
    assign slotGo = cpuSlot_i;
`endif

    lspc_vram_addr_step uAddrStep (
        .addr_i     (addr_q),
        .mod_i      (regVramMod_i),
        .addrNext_o (addrStep_d)
    );

    // A CPU address load outranks everything, including a slot in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            addr_q      <= VRAM_LOW_FIRST;
            writeData_q <= 16'h0000;
            lowRead_q   <= 16'h0000;
            highRead_q  <= 16'h0000;
            lowWe_q     <= 1'b0;
            highWe_q    <= 1'b0;
            rd_q        <= 1'b0;
            writeDone_q <= 1'b0;
        end else begin
            lowWe_q     <= 1'b0;
            highWe_q    <= 1'b0;
            rd_q        <= 1'b0;
            writeDone_q <= 1'b0;
            if (addrLoad_i) begin
                addr_q  <= regVramAddr_i;
                state_q <= ST_RD_WAIT;
                if (state_q == ST_WR_WAIT || state_q == ST_WR_DO) begin
                    writeDone_q <= 1'b1;
                end
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (vramWriteReq_i) begin
                            writeData_q <= regVramRw_i;
                            state_q     <= ST_WR_WAIT;
                        end
                    end
                    ST_WR_WAIT: begin
                        if (slotGo) begin
                            if (isHighRegion(addr_q)) begin
                                highWe_q <= 1'b1;
                            end else begin
                                lowWe_q <= 1'b1;
                            end
                            state_q <= ST_WR_DO;
                        end
                    end
                    ST_WR_DO: begin
                        writeDone_q <= 1'b1;
                        addr_q      <= addrStep_d;
                        state_q     <= ST_RD_WAIT;
                    end
                    ST_RD_WAIT: begin
                        if (slotGo) begin
                            rd_q    <= 1'b1;
                            state_q <= ST_RD_DO;
                        end
                    end
                    ST_RD_DO: begin
                        state_q <= ST_RD_CAP;
                    end
                    ST_RD_CAP: begin
                        if (isHighRegion(addr_q)) begin
                            highRead_q <= vramRdata_i;
                        end else begin
                            lowRead_q <= vramRdata_i;
                        end
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A load landing during WR_DO must suppress the strobe already on the bus.
    assign vramLowWe_o    = lowWe_q & ~addrLoad_i;
    assign vramHighWe_o   = highWe_q & ~addrLoad_i;
    assign vramRd_o       = rd_q;
    assign vramAddr_o     = addr_q;
    assign vramWdata_o    = writeData_q;
    assign vramLowRead_o  = lowRead_q;
    assign vramHighRead_o = highRead_q;
    assign writeDone_o    = writeDone_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: doc/lspc_vram_cpu_port.md
LSPC_VRAM_CPU_PORT -- requirements
Module: lspc_vram_cpu_port

Interface
REQ-001 SHALL have CLK, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have RESET, input, 1: synchronous, active-high reset.
REQ-003 SHALL have ADDR_LOAD, input, 1: one-cycle pulse, CPU wrote REG_VRAMADDR.
REQ-004 SHALL have REG_VRAMADDR, input, 16: CPU-written VRAM address.
REQ-005 SHALL have REG_VRAMMOD, input, 16: signed auto-increment step.
REQ-006 SHALL have REG_VRAMRW, input, 16: CPU write data.
REQ-007 SHALL have VRAM_WRITE_REQ, input, 1: level, pending CPU write.
REQ-008 SHALL have CPU_SLOT, input, 1: one-cycle pulse marking a CPU VRAM access window.
REQ-009 SHALL have VRAM_ADDR, output, 16: VRAM address; bit 15 selects fast (high) VRAM.
REQ-010 SHALL have VRAM_WDATA, output, 16: write data.
REQ-011 SHALL have VRAM_LOW_WE / VRAM_HIGH_WE, output, 1 each: write strobes.
REQ-012 SHALL have VRAM_RD, output, 1: read strobe.
REQ-013 SHALL have VRAM_RDATA, input, 16: read data, valid the cycle after VRAM_RD.
REQ-014 SHALL have VRAM_LOW_READ / VRAM_HIGH_READ, output, 16 each: prefetched read-back latches.
REQ-015 SHALL have WRITE_DONE, output, 1: one-cycle pulse, clears the write-request flag.
REQ-016 SHALL have BUSY, output, 1: high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, WR_WAIT, WR_DO, RD_WAIT, RD_DO, RD_CAP.
REQ-018 ADDR_LOAD SHALL load the address register from REG_VRAMADDR, then enter RD_WAIT from any state.
REQ-019 In IDLE, VRAM_WRITE_REQ high SHALL latch REG_VRAMRW and enter WR_WAIT.
REQ-020 WR_WAIT SHALL enter WR_DO on CPU_SLOT; WR_DO SHALL assert exactly one WE (HIGH_WE if addr[15], else LOW_WE) for one cycle.
REQ-021 The cycle after WR_DO SHALL pulse WRITE_DONE and set addr = {addr[15], addr[14:0] + REG_VRAMMOD[14:0]} mod 2^15; the FSM SHALL then enter RD_WAIT.
REQ-022 RD_WAIT SHALL enter RD_DO on CPU_SLOT; RD_DO asserts VRAM_RD for one cycle; RD_CAP stores VRAM_RDATA into HIGH_READ if addr[15], else LOW_READ, then returns to IDLE.
REQ-023 ADDR_LOAD in WR_WAIT or WR_DO SHALL cancel the write (no WE in that cycle or after), pulse WRITE_DONE once, and load the new address.
REQ-024 ADDR_LOAD coincident with CPU_SLOT SHALL take priority; the slot SHALL be ignored.
REQ-025 CPU_SLOT in IDLE SHALL have no effect; VRAM_WRITE_REQ is not sampled outside IDLE.
REQ-026 Address wrap: 0x7FFF + 1 -> 0x0000; 0xFFFF + 1 -> 0x8000; step 0xFFFF decrements.

Reset
REQ-027 RESET SHALL force IDLE; address register, VRAM_WDATA, both read latches = 0x0000; all strobes, WRITE_DONE and BUSY = 0.
REQ-028 RESET mid-operation SHALL drop any pending write without pulsing WRITE_DONE.

Configuration
REQ-029 Macro LSPC_CPU_PORT_OVERCLOCK_EN, when defined, SHALL add input OVERCLOCK (1 bit); when OVERCLOCK is high, WR_WAIT and RD_WAIT SHALL advance without CPU_SLOT.
REQ-030 When LSPC_CPU_PORT_OVERCLOCK_EN is undefined, the OVERCLOCK port SHALL be absent and every access SHALL wait for CPU_SLOT.

Structure
REQ-031 The state enum, VRAM region constants (LOW 0x0000-0x7FFF, HIGH 0x8000-0xFFFF) and 16-bit word type SHALL reside in package lspc_pkg.
REQ-032 Address stepping SHALL be one combinational sub-module, lspc_vram_addr_step.

Verification
REQ-033 Load address 0x1234, slot each 4 cycles -> one VRAM_RD at 0x1234; LOW_READ = RDATA.
REQ-034 Address 0x8010, MOD 1, write 0xABCD -> HIGH_WE once with data 0xABCD; WRITE_DONE 1 cycle later; addr 0x8011; prefetch read at 0x8011.
REQ-035 Address 0x7FFF, MOD 1, write -> next address 0x0000; address 0xFFFF -> 0x8000.
REQ-036 Write pending, ADDR_LOAD 0x0100 before slot -> no WE; one WRITE_DONE; read at 0x0100.
REQ-037 RESET asserted in WR_WAIT -> next cycle IDLE, no WE, no WRITE_DONE, outputs zero.
REQ-038 With macro defined and OVERCLOCK = 1, CPU_SLOT = 0 -> write completes in 2 cycles, read capture within 3 further cycles.
